// File: rtl/svcs_hs_trnx_framer.sv
// SVCS handshake transaction framer: round-robin over N_CH producers, emits header + payload words.
// Optional checksum trailer word is enabled by defining SVCS_HS_CHECKSUM_EN.
module svcs_hs_trnx_framer #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int ID_W   = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       req_valid,
  output logic [N_CH-1:0]       req_ready,
  input  logic [N_CH*DATA_W-1:0] req_trnx_type,
  input  logic [N_CH*DATA_W-1:0] req_data_type,
  input  logic [N_CH*CNT_W-1:0] req_n_payloads,
  input  logic [N_CH-1:0]       pl_valid,
  output logic [N_CH-1:0]       pl_ready,
  input  logic [N_CH*DATA_W-1:0] pl_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic [CH_W-1:0]       out_ch,
  output logic                  busy,
  output logic [31:0]           frame_cnt
);

`ifdef SVCS_HS_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY} state_t;
`endif

  state_t              state_r, state_nx_s;
  logic [1:0]          beat_r, beat_nx_s;
  logic [CH_W-1:0]     rr_r, ch_r, grant_s;
  logic [CH_W:0]       pick_s;
  logic [ID_W-1:0]     id_cnt_r, id_r;
  logic [DATA_W-1:0]   dtype_r;
  logic [CNT_W-1:0]    npl_r;
  logic                load_s, accept_s, cnt_dec_s;
  logic                ld_word_s, ld_sof_s, ld_eof_s;
  logic [DATA_W-1:0]   ld_data_s;

  // First requesting channel at or after ptr; MSB flags that one was found.
  function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] v, input logic [CH_W-1:0] ptr);
    logic [CH_W:0] res;
    int idx;
    res = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      if (!res[CH_W] && v[idx]) res = {1'b1, CH_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] csum_next(input logic [DATA_W-1:0] acc, input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

  assign load_s  = !out_valid || out_ready;
  assign pick_s  = rr_pick(req_valid, rr_r);
  assign grant_s = pick_s[CH_W-1:0];
  assign busy    = (state_r != ST_IDLE) || out_valid;

`ifdef SVCS_HS_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
`endif

  // Next-state, handshake strobes and the word offered to the output register.
  always_comb begin
    state_nx_s = state_r;
    beat_nx_s  = beat_r;
    req_ready  = '0;
    pl_ready   = '0;
    accept_s   = 1'b0;
    cnt_dec_s  = 1'b0;
    ld_word_s  = 1'b0;
    ld_sof_s   = 1'b0;
    ld_eof_s   = 1'b0;
    ld_data_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (!rst && pick_s[CH_W] && load_s) begin
          accept_s           = 1'b1;
          req_ready[grant_s] = 1'b1;
          ld_word_s          = 1'b1;
          ld_sof_s           = 1'b1;
          ld_data_s          = req_trnx_type[grant_s*DATA_W +: DATA_W];
          beat_nx_s          = 2'd1;
          state_nx_s         = ST_HDR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (load_s) begin
          ld_word_s = 1'b1;
          beat_nx_s = beat_r + 2'd1;
          case (beat_r)
            2'd1:    ld_data_s = DATA_W'(id_r);
            2'd2:    ld_data_s = dtype_r;
            2'd3:    ld_data_s = DATA_W'(npl_r);
            default: ld_data_s = '0;
          endcase
          if (beat_r == 2'd3) begin
`ifdef SVCS_HS_CHECKSUM_EN
            state_nx_s = (npl_r == '0) ? ST_CSUM : ST_PAY;
`else
            ld_eof_s   = (npl_r == '0);
            state_nx_s = (npl_r == '0) ? ST_IDLE : ST_PAY;
`endif
          end else begin
            state_nx_s = ST_HDR;
          end
        end else begin
          state_nx_s = ST_HDR;
        end
      end
      ST_PAY: begin
        pl_ready[ch_r] = !rst && load_s;
        if (load_s && pl_valid[ch_r]) begin
          ld_word_s = 1'b1;
          cnt_dec_s = 1'b1;
          ld_data_s = pl_data[ch_r*DATA_W +: DATA_W];
          if (npl_r == CNT_W'(1)) begin
`ifdef SVCS_HS_CHECKSUM_EN
            state_nx_s = ST_CSUM;
`else
            ld_eof_s   = 1'b1;
            state_nx_s = ST_IDLE;
`endif
          end else begin
            state_nx_s = ST_PAY;
          end
        end else begin
          state_nx_s = ST_PAY;
        end
      end
`ifdef SVCS_HS_CHECKSUM_EN
      ST_CSUM: begin
        if (load_s) begin
          ld_word_s  = 1'b1;
          ld_eof_s   = 1'b1;
          ld_data_s  = csum_r;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_CSUM;
        end
      end
`endif
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM, arbitration pointer, id counter and latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      beat_r   <= 2'd0;
      rr_r     <= '0;
      ch_r     <= '0;
      id_cnt_r <= '0;
      id_r     <= '0;
      dtype_r  <= '0;
      npl_r    <= '0;
    end else begin
      state_r <= state_nx_s;
      beat_r  <= beat_nx_s;
      if (accept_s) begin
        rr_r     <= CH_W'((int'(grant_s) + 1) % N_CH);
        ch_r     <= grant_s;
        id_r     <= id_cnt_r;
        id_cnt_r <= id_cnt_r + ID_W'(1);
        dtype_r  <= req_data_type[grant_s*DATA_W +: DATA_W];
        npl_r    <= req_n_payloads[grant_s*CNT_W +: CNT_W];
      end else if (cnt_dec_s) begin
        npl_r <= npl_r - CNT_W'(1);
      end
    end
  end

  // Single output register; holds its word while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_ch    <= '0;
    end else if (load_s) begin
      out_valid <= ld_word_s;
      out_sof   <= ld_sof_s;
      out_eof   <= ld_eof_s;
      if (ld_word_s) out_data <= ld_data_s;
      if (accept_s)  out_ch   <= grant_s;
    end
  end

  // Completed-frame counter, counted on the accepted eof word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 32'd0;
    end else if (out_valid && out_ready && out_eof) begin
      frame_cnt <= frame_cnt + 32'd1;
    end
  end

`ifdef SVCS_HS_CHECKSUM_EN
  // Running XOR of every word loaded for the current frame, restarted on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_r <= '0;
    end else if (ld_word_s) begin
      csum_r <= accept_s ? ld_data_s : csum_next(csum_r, ld_data_s);
    end
  end
`endif

endmodule
